// File: rtl/kbd_pkg.sv
// Shared definitions for the PS/2 keyboard receiver.
//   PS2_EXT   - extended-key prefix byte
//   PS2_BREAK - key-release prefix byte
//   KEY_NONE  - bus_keyboard value while no key is held
//   frame_state_t - deframer state
package kbd_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] KEY_NONE  = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frame_state_t;

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 clock conditioning: 2-flop synchronizer, glitch filter and fall detector.
//   clock      - system clock
//   reset      - asynchronous active-low reset
//   ps2_clk    - raw PS/2 clock line (asynchronous)
//   fall_event - one-cycle pulse in the first cycle the filtered clock is low
// The filtered level only follows the synchronized line after FILTER_LEN
// consecutive samples that differ from it.
module ps2_clk_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic ps2_clk,
    output logic fall_event
);

    localparam int unsigned CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

    logic          sync1;
    logic          sync2;
    logic          filt;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            filt       <= 1'b1;
            cnt        <= '0;
            fall_event <= 1'b0;
        end else begin
            sync1      <= ps2_clk;
            sync2      <= sync1;
            fall_event <= 1'b0;
            if (sync2 == filt) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                filt       <= sync2;
                cnt        <= '0;
                fall_event <= filt;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver feeding the CPU keyboard byte.
//   clock        - system clock (single domain)
//   reset        - asynchronous active-low reset
//   ps2_clk      - raw PS/2 clock line
//   ps2_data     - raw PS/2 data line
//   bus_keyboard - make code of the held key, KEY_NONE when idle
//   key_valid    - one-cycle pulse whenever a make code is loaded
//   key_ext      - held code was E0-prefixed
//   frame_error  - one-cycle pulse on parity/stop error or timeout
module ps2_keyboard
    import kbd_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] bus_keyboard,
    output logic       key_valid,
    output logic       key_ext,
    output logic       frame_error
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);

    logic          fall_event;
    logic          data_s1;
    logic          data_sync;
    frame_state_t  state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          parity_bit;
    logic [TW-1:0] to_cnt;
    logic          ext_pend;
    logic          brk_pend;

    ps2_clk_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clock      (clock),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .fall_event (fall_event)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_s1   <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            data_s1   <= ps2_data;
            data_sync <= data_s1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shift        <= '0;
            parity_bit   <= 1'b0;
            to_cnt       <= '0;
            ext_pend     <= 1'b0;
            brk_pend     <= 1'b0;
            bus_keyboard <= KEY_NONE;
            key_ext      <= 1'b0;
            key_valid    <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            key_valid   <= 1'b0;
            frame_error <= 1'b0;
            // A fall event takes priority over an expiring timeout.
            if (fall_event) begin
                to_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (!data_sync) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shift <= {data_sync, shift[7:1]};
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    PARITY: begin
                        parity_bit <= data_sync;
                        state      <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if ((^{shift, parity_bit}) && data_sync) begin
                            if (shift == PS2_EXT) begin
                                ext_pend <= 1'b1;
                            end else if (shift == PS2_BREAK) begin
                                brk_pend <= 1'b1;
                            end else begin
                                ext_pend <= 1'b0;
                                brk_pend <= 1'b0;
                                if (brk_pend) begin
                                    // Release only clears the key it names.
                                    if (shift == bus_keyboard && ext_pend == key_ext) begin
                                        bus_keyboard <= KEY_NONE;
                                        key_ext      <= 1'b0;
                                    end
                                end else begin
                                    bus_keyboard <= shift;
                                    key_ext      <= ext_pend;
                                    key_valid    <= 1'b1;
                                end
                            end
                        end else begin
                            frame_error <= 1'b1;
                            ext_pend    <= 1'b0;
                            brk_pend    <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (to_cnt == TO_MAX) begin
                    state       <= IDLE;
                    to_cnt      <= '0;
                    frame_error <= 1'b1;
                    ext_pend    <= 1'b0;
                    brk_pend    <= 1'b0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard.sv
module tb_ps2_keyboard;

    localparam int unsigned FILTER_LEN = 8;
    localparam int unsigned TIMEOUT    = 600;
    // PS/2 half period in system clocks, shortened to keep the run small.
    localparam int unsigned HALF       = 25;
    localparam int unsigned GAP        = 60;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] bus_keyboard;
    logic       key_valid;
    logic       key_ext;
    logic       frame_error;

    ps2_keyboard #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .bus_keyboard (bus_keyboard),
        .key_valid    (key_valid),
        .key_ext      (key_ext),
        .frame_error  (frame_error)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        bit          is_err;
        logic [7:0]  code;
        bit          ext;
        int unsigned lo;
        int unsigned hi;
    } ev_t;
    ev_t exp_q[$];

    // Reference keyboard state
    logic [7:0] m_held = 8'hFF;
    bit         m_ext  = 1'b0;
    bit         m_epend = 1'b0;
    bit         m_bpend = 1'b0;
    int unsigned last_fall = 0;

    // Monitor: every output pulse must match the next expected event.
    always @(negedge clock) begin
        if (reset && (key_valid || frame_error)) begin
            checks++;
            if (key_valid && frame_error) begin
                fails++;
                $display("FAIL both_pulses: key_valid=%0b frame_error=%0b, required never both", key_valid, frame_error);
            end else if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pulse: key_valid=%0b frame_error=%0b code=%02h at cycle %0d, required no pulse",
                         key_valid, frame_error, bus_keyboard, cyc);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (e.is_err != frame_error || bus_keyboard != e.code || key_ext != e.ext ||
                    (e.hi != 0 && (cyc < e.lo || cyc > e.hi))) begin
                    fails++;
                    $display("FAIL event: got err=%0b code=%02h ext=%0b cyc=%0d, required err=%0b code=%02h ext=%0b cyc=[%0d..%0d]",
                             frame_error, bus_keyboard, key_ext, cyc, e.is_err, e.code, e.ext, e.lo, e.hi);
                end
            end
        end
    end

    task automatic push_ev(input bit is_err, input int unsigned lo, input int unsigned hi);
        ev_t e;
        e.is_err = is_err;
        e.code   = m_held;
        e.ext    = m_ext;
        e.lo     = lo;
        e.hi     = hi;
        exp_q.push_back(e);
    endtask

    task automatic model_byte(input logic [7:0] b, input bit bad);
        if (bad) begin
            m_epend = 0;
            m_bpend = 0;
            push_ev(1'b1, 0, 0);
        end else if (b == 8'hE0) begin
            m_epend = 1;
        end else if (b == 8'hF0) begin
            m_bpend = 1;
        end else begin
            if (m_bpend) begin
                if (b == m_held && m_epend == m_ext) begin
                    m_held = 8'hFF;
                    m_ext  = 0;
                end
            end else begin
                m_held = b;
                m_ext  = m_epend;
                push_ev(1'b0, 0, 0);
            end
            m_epend = 0;
            m_bpend = 0;
        end
    endtask

    task automatic send_bit(input bit b, input bit glitch);
        @(negedge clock);
        ps2_data = b;
        if (glitch) begin
            repeat (5) @(negedge clock);
            ps2_clk = 1'b0;
            repeat (FILTER_LEN - 1) @(negedge clock);
            ps2_clk = 1'b1;
            repeat (HALF - 5 - (FILTER_LEN - 1)) @(negedge clock);
        end else begin
            repeat (HALF) @(negedge clock);
        end
        ps2_clk = 1'b0;
        last_fall = cyc;
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b1;
    endtask

    // kind: 0 good, 1 parity flipped, 2 stop bit low. nbits<11 aborts the frame.
    task automatic send_frame(input logic [7:0] b, input int kind, input int nbits, input int glitch_bit);
        logic [10:0] bits;
        bits = {(kind == 2) ? 1'b0 : 1'b1, (~^b) ^ (kind == 1), b, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(bits[i], i == glitch_bit);
        ps2_data = 1'b1;
        repeat (GAP) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input int kind, input int glitch_bit);
        model_byte(b, kind != 0);
        send_frame(b, kind, 11, glitch_bit);
    endtask

    task automatic check_held(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: %0d events outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end else if (bus_keyboard != m_held || key_ext != m_ext) begin
            fails++;
            $display("FAIL %s_held: bus=%02h ext=%0b, required bus=%02h ext=%0b",
                     name, bus_keyboard, key_ext, m_held, m_ext);
        end
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if (bus_keyboard != 8'hFF || key_valid !== 1'b0 || key_ext !== 1'b0 || frame_error !== 1'b0) begin
            fails++;
            $display("FAIL %s: bus=%02h kv=%0b ext=%0b ferr=%0b, required FF 0 0 0",
                     name, bus_keyboard, key_valid, key_ext, frame_error);
        end
    endtask

    initial begin
        repeat (95000) @(posedge clock);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
        $fatal(1);
    end

    initial begin
        logic [7:0] code;
        int r;
        int kind;
        int g;

        repeat (4) @(negedge clock);
        check_reset_values("reset_state");
        reset = 1'b1;
        repeat (20) @(negedge clock);

        // Make, matching break, non-matching break
        send_byte(8'h1C, 0, -1);
        check_held("make_1c", 200);
        send_byte(8'hF0, 0, -1);
        send_byte(8'h1C, 0, -1);
        check_held("break_1c", 200);
        send_byte(8'h1C, 0, -1);
        send_byte(8'hF0, 0, -1);
        send_byte(8'h1B, 0, -1);
        check_held("break_other", 200);

        // Extended make and break
        send_byte(8'hE0, 0, -1);
        send_byte(8'h75, 0, -1);
        check_held("ext_make", 200);
        send_byte(8'hE0, 0, -1);
        send_byte(8'hF0, 0, -1);
        send_byte(8'h75, 0, -1);
        check_held("ext_break", 200);

        // Bad frames leave the held key alone
        send_byte(8'h1C, 0, -1);
        send_byte(8'h1C, 1, -1);
        check_held("parity_err", 200);
        send_byte(8'h1C, 2, -1);
        check_held("stop_err", 200);

        // Timeout after start + 5 data bits
        send_frame(8'h5A, 0, 6, -1);
        m_epend = 0;
        m_bpend = 0;
        push_ev(1'b1, last_fall + TIMEOUT + FILTER_LEN, last_fall + TIMEOUT + FILTER_LEN + 4);
        check_held("timeout", 3 * TIMEOUT);
        send_byte(8'h29, 0, -1);
        check_held("after_timeout", 200);

        // Short glitch on ps2_clk must not shift an extra bit
        send_byte(8'h33, 0, 4);
        check_held("glitch", 200);

        // Randomized traffic
        for (int i = 0; i < 25; i++) begin
            r = int'($urandom_range(0, 9));
            g = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 10)) : -1;
            code = 8'($urandom_range(1, 8'h7F));
            if (r <= 4) begin
                if ($urandom_range(0, 2) == 0) send_byte(8'hE0, 0, -1);
                send_byte(code, 0, g);
            end else if (r <= 6 && m_held != 8'hFF) begin
                if (m_ext) send_byte(8'hE0, 0, -1);
                send_byte(8'hF0, 0, -1);
                send_byte(m_held, 0, g);
            end else if (r == 7) begin
                if ($urandom_range(0, 1) == 1) send_byte(8'hE0, 0, -1);
                send_byte(8'hF0, 0, -1);
                send_byte(code, 0, g);
            end else if (r == 8) begin
                kind = int'($urandom_range(1, 2));
                send_byte(code, kind, g);
            end else if (m_held != 8'hFF) begin
                if (m_ext) send_byte(8'hE0, 0, -1);
                send_byte(m_held, 0, g);
            end else begin
                send_byte(code, 0, g);
            end
            check_held("random", 200);
        end

        // Reset in the middle of a frame
        send_byte(8'h1C, 0, -1);
        check_held("pre_reset", 200);
        send_frame(8'h1C, 0, 4, -1);
        reset = 1'b0;
        #1;
        check_reset_values("mid_frame_reset");
        m_held  = 8'hFF;
        m_ext   = 0;
        m_epend = 0;
        m_bpend = 0;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        repeat (20) @(negedge clock);
        send_byte(8'h1C, 0, -1);
        check_held("post_reset", 200);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
